// File: rtl/reg_write_arbiter.sv
// reg_write_arbiter: four requesters share one 8-bit register through a
// round-robin ownership grant. While a requester owns the register, only its
// write lane is accepted. Every ownership is followed by at least one IDLE
// cycle, so consecutive grants are always separated by a gnt = 0 bubble.
//
// Optional build macro REG_ARB_TIMEOUT_EN adds an ownership watchdog. With it,
// an owner that holds req for TIMEOUT_CYCLES owned cycles is forced off the bus
// and timeout pulses for one cycle. Without it, ownership is unbounded and
// timeout is tied low.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_IDLE  | no owner; round-robin search from r_ptr over req each cycle
// ST_OWNED | r_owner holds the register; its wr_en lane loads q
module reg_write_arbiter #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  req,
    input  logic [3:0]  wr_en,
    input  logic [31:0] wr_data,
    output logic [3:0]  gnt,
    output logic [1:0]  owner,
    output logic        busy,
    output logic [7:0]  q,
    output logic [7:0]  qn,
    output logic        timeout
);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_OWNED = 1'b1
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [1:0]  r_ptr;
    logic [1:0]  w_ptr_nxt;
    logic [1:0]  r_owner;
    logic [1:0]  w_owner_nxt;
    logic [3:0]  r_gnt;
    logic [3:0]  w_gnt_nxt;
    logic [7:0]  r_q;
    logic [7:0]  w_q_nxt;
    logic [1:0]  w_pick;
    logic        w_pick_vld;
    logic [7:0]  w_owner_byte;
    logic        w_expire;

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("reg_write_arbiter: TIMEOUT_CYCLES must be at least 1");
    end

    assign w_owner_byte = wr_data[{r_owner, 3'b000} +: 8];

`ifdef REG_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] r_cnt;
    logic             r_timeout;

    // The counter value during the k-th owned cycle is k-1, so the last
    // permitted cycle is the one that sees TIMEOUT_CYCLES-1.
    assign w_expire = (r_state == ST_OWNED) && req[r_owner] &&
                      (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    // Ownership-length counter (held clear while idle) and release pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt     <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_timeout <= w_expire;
            if (r_state == ST_IDLE) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign timeout = r_timeout;
`else
    assign w_expire = 1'b0;
    assign timeout  = 1'b0;
`endif

    // Round-robin search: walk ptr+3 down to ptr so the lowest offset wins.
    always_comb begin
        w_pick     = r_ptr;
        w_pick_vld = 1'b0;
        for (int i = 3; i >= 0; i--) begin
            if (req[r_ptr + 2'(i)]) begin
                w_pick     = r_ptr + 2'(i);
                w_pick_vld = 1'b1;
            end
        end
    end

    // Next-state, grant, pointer and register-write decode.
    always_comb begin
        w_state_nxt = r_state;
        w_gnt_nxt   = r_gnt;
        w_owner_nxt = r_owner;
        w_ptr_nxt   = r_ptr;
        w_q_nxt     = r_q;
        case (r_state)
            ST_IDLE: begin
                w_gnt_nxt = 4'b0000;
                if (w_pick_vld) begin
                    w_state_nxt = ST_OWNED;
                    w_gnt_nxt   = 4'b0001 << w_pick;
                    w_owner_nxt = w_pick;
                end
            end
            ST_OWNED: begin
                // A write in the release cycle still lands.
                if (wr_en[r_owner]) begin
                    w_q_nxt = w_owner_byte;
                end
                if (!req[r_owner] || w_expire) begin
                    w_state_nxt = ST_IDLE;
                    w_gnt_nxt   = 4'b0000;
                    w_ptr_nxt   = r_owner + 2'd1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_gnt_nxt   = 4'b0000;
            end
        endcase
    end

    // State and datapath registers; reset overrides everything.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_gnt   <= 4'b0000;
            r_owner <= 2'd0;
            r_ptr   <= 2'd0;
            r_q     <= 8'h00;
        end else begin
            r_state <= w_state_nxt;
            r_gnt   <= w_gnt_nxt;
            r_owner <= w_owner_nxt;
            r_ptr   <= w_ptr_nxt;
            r_q     <= w_q_nxt;
        end
    end

    assign gnt   = r_gnt;
    assign owner = r_owner;
    assign busy  = (r_state == ST_OWNED);
    assign q     = r_q;
    assign qn    = ~r_q;

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Directed testbench for reg_write_arbiter. Inputs change 1 ns after each
// rising edge and outputs are checked at that same point. With
// REG_ARB_TIMEOUT_EN defined the DUT is built with TIMEOUT_CYCLES = 4 and the
// forced release is expected; otherwise the same owner must keep its grant.
module tb_reg_write_arbiter;

`ifdef REG_ARB_TIMEOUT_EN
    localparam int TB_TO = 4;
`else
    localparam int TB_TO = 16;
`endif

    logic        clk;
    logic        reset;
    logic [3:0]  req;
    logic [3:0]  wr_en;
    logic [31:0] wr_data;
    logic [3:0]  gnt;
    logic [1:0]  owner;
    logic        busy;
    logic [7:0]  q;
    logic [7:0]  qn;
    logic        timeout;

    int n_checks = 0;
    int n_errors = 0;

    reg_write_arbiter #(.TIMEOUT_CYCLES(TB_TO)) u_dut (
        .clk     (clk),
        .reset   (reset),
        .req     (req),
        .wr_en   (wr_en),
        .wr_data (wr_data),
        .gnt     (gnt),
        .owner   (owner),
        .busy    (busy),
        .q       (q),
        .qn      (qn),
        .timeout (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [3:0] exp_gnt;

        // Reset held two cycles with every request and write asserted.
        reset   = 1'b1;
        req     = 4'hF;
        wr_en   = 4'hF;
        wr_data = 32'hDEADBEEF;
        tick();
        tick();
        check_val("rst_gnt",     32'(gnt),     32'h0);
        check_val("rst_q",       32'(q),       32'h00);
        check_val("rst_qn",      32'(qn),      32'hFF);
        check_val("rst_busy",    32'(busy),    32'h0);
        check_val("rst_owner",   32'(owner),   32'h0);
        check_val("rst_timeout", 32'(timeout), 32'h0);

        // Idle with no requests; a stray write while idle must be dropped.
        reset = 1'b0;
        req   = 4'h0;
        wr_en = 4'h0;
        tick();
        check_val("idle_gnt", 32'(gnt), 32'h0);
        wr_en   = 4'b0001;
        wr_data = 32'h00000077;
        tick();
        check_val("idle_wr_q",    32'(q),    32'h00);
        check_val("idle_wr_busy", 32'(busy), 32'h0);

        // Single requester 2 and one write of A5.
        wr_en = 4'h0;
        req   = 4'b0100;
        tick();
        check_val("sw_gnt",   32'(gnt),   32'b0100);
        check_val("sw_owner", 32'(owner), 32'd2);
        check_val("sw_busy",  32'(busy),  32'h1);
        wr_en   = 4'b0100;
        wr_data = 32'h00A50000;
        tick();
        check_val("sw_q",  32'(q),  32'hA5);
        check_val("sw_qn", 32'(qn), 32'h5A);

        // Lanes 0 and 3 write while 2 owns: ignored.
        wr_en   = 4'b1001;
        wr_data = 32'h99000011;
        tick();
        check_val("sw_nonowner_q", 32'(q), 32'hA5);

        // Release.
        wr_en = 4'h0;
        req   = 4'h0;
        tick();
        check_val("sw_rel_gnt",  32'(gnt),  32'h0);
        check_val("sw_rel_busy", 32'(busy), 32'h0);

        // Round robin from a fresh reset with all four requesting.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        req   = 4'hF;
        for (int k = 0; k < 5; k++) begin
            int e;
            e = k % 4;
            exp_gnt = 4'b0001 << e;
            tick();
            check_val($sformatf("rr%0d_gnt", k),   32'(gnt),   32'(exp_gnt));
            check_val($sformatf("rr%0d_owner", k), 32'(owner), 32'(e));
            if (e == 1) begin
                wr_en   = 4'b1001;
                wr_data = 32'h99000011;
            end
            tick();
            check_val($sformatf("rr%0d_hold", k), 32'(gnt), 32'(exp_gnt));
            if (e == 1) begin
                check_val("rr_nonowner_q", 32'(q), 32'h00);
            end
            wr_en = 4'h0;
            req   = 4'hF & ~exp_gnt;
            if (e == 3) begin
                wr_en   = 4'b1000;
                wr_data = 32'h3C000000;
            end
            tick();
            check_val($sformatf("rr%0d_bubble", k), 32'(gnt),  32'h0);
            check_val($sformatf("rr%0d_busy", k),   32'(busy), 32'h0);
            if (e == 3) begin
                check_val("rr_relwr_q",  32'(q),  32'h3C);
                check_val("rr_relwr_qn", 32'(qn), 32'hC3);
            end
            wr_en = 4'h0;
            req   = 4'hF;
        end

        // Reset in the middle of an ownership with a write from the owner.
        req = 4'b0001;
        tick();
        check_val("rd_gnt_pre", 32'(gnt), 32'b0001);
        reset   = 1'b1;
        wr_en   = 4'b0001;
        wr_data = 32'h000000AB;
        tick();
        check_val("rd_gnt",  32'(gnt),  32'h0);
        check_val("rd_q",    32'(q),    32'h00);
        check_val("rd_busy", 32'(busy), 32'h0);

        // ptr restarts at 0: requester 0 wins over waiting requester 1.
        reset = 1'b0;
        wr_en = 4'h0;
        req   = 4'b0011;
        tick();
        check_val("to_gnt0",  32'(gnt),   32'b0001);
        check_val("to_owner", 32'(owner), 32'd0);
        for (int c = 0; c < 3; c++) begin
            tick();
            check_val($sformatf("to_hold%0d", c), 32'(gnt),     32'b0001);
            check_val($sformatf("to_tmo%0d", c),  32'(timeout), 32'h0);
        end
        wr_en   = 4'b0001;
        wr_data = 32'h0000005E;
        tick();
        check_val("to_wr_q", 32'(q), 32'h5E);
`ifdef REG_ARB_TIMEOUT_EN
        check_val("to_rel_gnt",  32'(gnt),     32'h0);
        check_val("to_pulse",    32'(timeout), 32'h1);
        check_val("to_rel_busy", 32'(busy),    32'h0);
`else
        check_val("nto_gnt",  32'(gnt),     32'b0001);
        check_val("nto_tmo",  32'(timeout), 32'h0);
`endif
        wr_en = 4'h0;
        tick();
`ifdef REG_ARB_TIMEOUT_EN
        check_val("to_next_gnt",   32'(gnt),     32'b0010);
        check_val("to_pulse_end",  32'(timeout), 32'h0);
`else
        check_val("nto_gnt_still", 32'(gnt),     32'b0001);
        check_val("nto_tmo_still", 32'(timeout), 32'h0);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
